// File: rtl/data_reg.sv
// data_reg: JTAG-style test data register clocked by TCK.
// A serial capture/shift chain (TDI -> MSB ... LSB -> TDO) sits in front of a
// parallel update (shadow) register that drives DR_out. Each bit position is a
// data_reg_cell; the top resolves strobe priority once and fans it out.

module data_reg_cell (
  input  logic TCK,
  input  logic rst,
  input  logic cap,     // load shift stage from shadow
  input  logic shf,     // load shift stage from upstream neighbour
  input  logic upd,     // load shadow from shift stage
  input  logic ser_in,  // upstream bit (TDI for the MSB)
  output logic sh_q,
  output logic up_q
);

  // One bit of the shift chain plus its shadow; reset wins over every strobe.
  always_ff @(posedge TCK) begin
    if (rst) begin
      sh_q <= 1'b0;
      up_q <= 1'b0;
    end else if (cap) begin
      sh_q <= up_q;
    end else if (shf) begin
      sh_q <= ser_in;
    end else if (upd) begin
      up_q <= sh_q;
    end
  end

endmodule

module data_reg #(
  parameter int DR_length = 5
) (
  input  logic                 TCK,
  input  logic                 rst,
  input  logic                 tdr_select,
  input  logic                 TDI,
  input  logic                 Capture_DR,
  input  logic                 Shift_DR,
  input  logic                 Update_DR,
  output logic                 TDO,
  output logic [DR_length-1:0] DR_out
);

  logic                 cap, shf, upd;
  logic [DR_length-1:0] shift_reg;
  logic [DR_length-1:0] update_reg;
  logic [DR_length-1:0] ser_in;

  // Strobes are one-hot after this point: Capture > Shift > Update, all
  // suppressed when another register owns the scan path.
  assign cap = tdr_select & Capture_DR;
  assign shf = tdr_select & ~Capture_DR & Shift_DR;
  assign upd = tdr_select & ~Capture_DR & ~Shift_DR & Update_DR;

  // Each bit takes its upstream neighbour on shift; TDI feeds the MSB.
  assign ser_in = {TDI, shift_reg[DR_length-1:1]};

  for (genvar i = 0; i < DR_length; i++) begin : g_bit
    data_reg_cell u_cell (
      .TCK    (TCK),
      .rst    (rst),
      .cap    (cap),
      .shf    (shf),
      .upd    (upd),
      .ser_in (ser_in[i]),
      .sh_q   (shift_reg[i]),
      .up_q   (update_reg[i])
    );
  end

  // The LSB is the bit leaving on the next shift edge; quiet when deselected.
  assign TDO    = tdr_select ? shift_reg[0] : 1'b0;
  assign DR_out = update_reg;

endmodule

// File: tb/tb_data_reg.sv
// Directed bench for data_reg (DR_length = 5) with hand-computed expectations.
module tb_data_reg;

  localparam int W = 5;

  logic         TCK = 1'b0;
  logic         rst, tdr_select, TDI, Capture_DR, Shift_DR, Update_DR;
  logic         TDO;
  logic [W-1:0] DR_out;

  int n_run  = 0;
  int n_fail = 0;

  data_reg #(.DR_length(W)) dut (
    .TCK        (TCK),
    .rst        (rst),
    .tdr_select (tdr_select),
    .TDI        (TDI),
    .Capture_DR (Capture_DR),
    .Shift_DR   (Shift_DR),
    .Update_DR  (Update_DR),
    .TDO        (TDO),
    .DR_out     (DR_out)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one TCK rising edge and settle just past it.
  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic idle();
    Capture_DR = 1'b0; Shift_DR = 1'b0; Update_DR = 1'b0; TDI = 1'b0;
  endtask

  task automatic capture();
    Capture_DR = 1'b1; step(); Capture_DR = 1'b0;
  endtask

  task automatic update();
    Update_DR = 1'b1; step(); Update_DR = 1'b0;
  endtask

  // Shift one bit in, checking the TDO bit presented before the edge and
  // that DR_out is untouched by the shift.
  task automatic shift_bit(input string tag, input logic b, input logic exp_tdo,
                           input logic [W-1:0] exp_dr);
    TDI = b; Shift_DR = 1'b1;
    chk({tag, "_tdo"}, {31'd0, TDO}, {31'd0, exp_tdo});
    step();
    Shift_DR = 1'b0; TDI = 1'b0;
    chk({tag, "_dr"}, {27'd0, DR_out}, {27'd0, exp_dr});
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] tdo_exp;

    rst = 1'b1; tdr_select = 1'b1; idle();

    // Reset with random strobes active
    for (int i = 0; i < 2; i++) begin
      Capture_DR = 1'($urandom); Shift_DR = 1'($urandom);
      Update_DR = 1'($urandom);  TDI = 1'($urandom);
      step();
      chk("rst_dr", {27'd0, DR_out}, 32'd0);
      chk("rst_tdo", {31'd0, TDO}, 32'd0);
    end
    rst = 1'b0; idle();
    step(); step();
    chk("post_rst_dr", {27'd0, DR_out}, 32'd0);

    // Deselected: everything ignored, TDO held low
    tdr_select = 1'b0;
    capture();
    pat = 5'b01001;  // bits fed LSB first: 1,0,0,1,0
    for (int i = 0; i < W; i++) shift_bit("desel", pat[i], 1'b0, 5'b00000);
    update();
    chk("desel_dr", {27'd0, DR_out}, 32'd0);
    chk("desel_tdo", {31'd0, TDO}, 32'd0);

    // Basic load of zeros, then 0,0,0,1,0 -> 01000
    tdr_select = 1'b1;
    capture();
    for (int i = 0; i < W; i++) shift_bit("load0", 1'b0, 1'b0, 5'b00000);
    update();
    chk("load0_dr", {27'd0, DR_out}, 32'd0);
    capture();
    pat = 5'b01000;
    for (int i = 0; i < W; i++) shift_bit("load1", pat[i], 1'b0, 5'b00000);
    chk("load1_pre_upd", {27'd0, DR_out}, 32'd0);
    update();
    chk("load1_dr", {27'd0, DR_out}, 32'h08);

    // Second load with readback of 01000 on TDO: 0,0,0,1,0
    capture();
    pat = 5'b00010; tdo_exp = 5'b01000;
    for (int i = 0; i < W; i++) shift_bit("load2", pat[i], tdo_exp[i], 5'b01000);
    update();
    chk("load2_dr", {27'd0, DR_out}, 32'h02);

    // Priority: all three strobes -> capture only (shift_reg = 00010)
    Capture_DR = 1'b1; Shift_DR = 1'b1; Update_DR = 1'b1;
    step(); idle();
    chk("pri3_dr", {27'd0, DR_out}, 32'h02);
    chk("pri3_tdo", {31'd0, TDO}, 32'd0);
    // Shift+Update with TDI=1 -> shift wins: 00010 -> 10001, DR_out unchanged
    Shift_DR = 1'b1; Update_DR = 1'b1; TDI = 1'b1;
    chk("pri2_tdo_pre", {31'd0, TDO}, 32'd0);
    step(); idle();
    chk("pri2_dr", {27'd0, DR_out}, 32'h02);
    // Drain 10001 LSB first: 1,0,0,0,1 (first bit already at TDO)
    tdo_exp = 5'b10001;
    for (int i = 0; i < W; i++) shift_bit("pri2_drain", 1'b0, tdo_exp[i], 5'b00010);

    // Reset mid-shift: capture 00010, 3 shifts of 1 -> 11100, then reset
    capture();
    tdo_exp = 5'b00010;
    for (int i = 0; i < 3; i++) shift_bit("mid", 1'b1, tdo_exp[i], 5'b00010);
    Shift_DR = 1'b1; TDI = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; idle();
    chk("mid_rst_dr", {27'd0, DR_out}, 32'd0);
    chk("mid_rst_tdo", {31'd0, TDO}, 32'd0);
    update();
    chk("mid_upd_dr", {27'd0, DR_out}, 32'd0);

    // Short shift: capture 0, two 1s -> 11000, update exposes captured bits low
    capture();
    shift_bit("short", 1'b1, 1'b0, 5'b00000);
    shift_bit("short", 1'b1, 1'b0, 5'b00000);
    update();
    chk("short_dr", {27'd0, DR_out}, 32'h18);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
